// File: rtl/getir_birimi.sv
// Instruction fetch unit: PC sequencing, one-deep ROM request tracking and a small beat FIFO toward decode.
// Optional macro GETIR_ADRES_DENETIM_EN replaces out-of-range fetches with a NOP and flags them on hata_c.
module getir_birimi #(
  parameter logic [31:0] BASLANGIC_ADRES = 32'h0000_0000,
  parameter int unsigned DERINLIK        = 2,
  parameter int unsigned ROM_KELIME      = 41
) (
  input  logic        clk_g,
  input  logic        rst_g,
  output logic [31:0] adres_c,
  output logic        ena_c,
  input  logic [31:0] buyruk_g,
  input  logic        dallan_g,
  input  logic [31:0] dallan_adres_g,
  output logic        gecerli_c,
  input  logic        hazir_g,
  output logic [31:0] buyruk_c,
  output logic [31:0] pc_c,
  output logic        hata_c
);

  localparam int unsigned    PW        = (DERINLIK > 2) ? 2 : 1;
  localparam int unsigned    CW        = $clog2(DERINLIK + 1);
  localparam logic [PW-1:0]  SON_IDX   = PW'(DERINLIK - 1);
  localparam logic [CW:0]    DERIN_GEN = (CW + 1)'(DERINLIK);

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   ucus_pc_q, ucus_pc_d;
  logic          ucus_q, ucus_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] sayac_q, sayac_d;
  logic [31:0]   mem_buyruk_q [DERINLIK];
  logic [31:0]   mem_pc_q     [DERINLIK];

  logic          cikis, yaz;
  logic [CW:0]   doluluk_sonra;
  logic [31:0]   yaz_buyruk;
  logic          unused_adres_lsb;

  assign unused_adres_lsb = ^dallan_adres_g[1:0];

  function automatic logic [PW-1:0] sonraki(input logic [PW-1:0] p);
    return (p == SON_IDX) ? '0 : p + 1'b1;
  endfunction

  assign adres_c   = pc_q;
  assign gecerli_c = (sayac_q != '0) && !rst_g;
  assign buyruk_c  = gecerli_c ? mem_buyruk_q[rd_q] : '0;
  assign pc_c      = gecerli_c ? mem_pc_q[rd_q]     : '0;

`ifdef GETIR_ADRES_DENETIM_EN
  logic mem_hata_q [DERINLIK];
  logic yaz_hata;
  assign yaz_hata   = {2'b00, ucus_pc_q[31:2]} >= ROM_KELIME;
  assign yaz_buyruk = yaz_hata ? 32'h0000_0013 : buyruk_g;
  assign hata_c     = gecerli_c && mem_hata_q[rd_q];
`else
  assign yaz_buyruk = buyruk_g;
  assign hata_c     = 1'b0;
`endif

  always_comb begin
    cikis = gecerli_c && hazir_g;
    yaz   = ucus_q && !dallan_g;
    // Occupancy after this cycle's pop, counting the word already in flight.
    doluluk_sonra = {1'b0, sayac_q} + {{CW{1'b0}}, ucus_q} - {{CW{1'b0}}, cikis};
    ena_c = !rst_g && !dallan_g && (doluluk_sonra < DERIN_GEN);

    pc_d      = pc_q;
    ucus_pc_d = ucus_pc_q;
    ucus_d    = ena_c;
    rd_d      = rd_q;
    wr_d      = wr_q;
    sayac_d   = sayac_q;
    if (ena_c) begin
      pc_d      = pc_q + 32'd4;
      ucus_pc_d = pc_q;
    end
    if (dallan_g) begin
      pc_d    = {dallan_adres_g[31:2], 2'b00};
      rd_d    = '0;
      wr_d    = '0;
      sayac_d = '0;
    end else begin
      if (yaz)   wr_d = sonraki(wr_q);
      if (cikis) rd_d = sonraki(rd_q);
      sayac_d = sayac_q + {{(CW-1){1'b0}}, yaz} - {{(CW-1){1'b0}}, cikis};
    end
  end

  always_ff @(posedge clk_g) begin
    if (rst_g) begin
      pc_q      <= BASLANGIC_ADRES;
      ucus_pc_q <= '0;
      ucus_q    <= 1'b0;
      rd_q      <= '0;
      wr_q      <= '0;
      sayac_q   <= '0;
    end else begin
      pc_q      <= pc_d;
      ucus_pc_q <= ucus_pc_d;
      ucus_q    <= ucus_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      sayac_q   <= sayac_d;
    end
  end

  always_ff @(posedge clk_g) begin
    if (!rst_g && yaz) begin
      mem_buyruk_q[wr_q] <= yaz_buyruk;
      mem_pc_q[wr_q]     <= ucus_pc_q;
`ifdef GETIR_ADRES_DENETIM_EN
      mem_hata_q[wr_q]   <= yaz_hata;
`endif
    end
  end

endmodule

// File: doc/getir_birimi.md
GETIR_BIRIMI -- requirements
Module: getir_birimi

Interface
REQ-001 Parameter BASLANGIC_ADRES, default 32'h0000_0000, SHALL be the program counter value after reset.
REQ-002 Parameter DERINLIK, default 2, SHALL be the instruction buffer depth in entries (legal 2..4).
REQ-003 Parameter ROM_KELIME, default 41, SHALL be the number of valid 32-bit words in the instruction ROM.
REQ-004 clk_g  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_g  input  1  synchronous, active-high reset.
REQ-006 adres_c  output  32  fetch address driven to the instruction ROM.
REQ-007 ena_c  output  1  ROM read enable; ROM returns the word for adres_c on buyruk_g one cycle later.
REQ-008 buyruk_g  input  32  registered ROM read data.
REQ-009 dallan_g  input  1  redirect request from execute.
REQ-010 dallan_adres_g  input  32  redirect target.
REQ-011 gecerli_c  output  1  instruction beat valid toward decode.
REQ-012 hazir_g  input  1  decode ready.
REQ-013 buyruk_c / pc_c  output  32 / 32  instruction and its address for the head beat.
REQ-014 hata_c  output  1  head beat fetched from out-of-range address.

Function
REQ-015 The block SHALL hold pc_r, an in-flight flag ucus_r, and a FIFO of DERINLIK entries {buyruk, pc, hata}; adres_c SHALL equal pc_r at all times.
REQ-016 Pop (cikis) SHALL occur when gecerli_c && hazir_g; gecerli_c SHALL be 1 iff FIFO non-empty; buyruk_c/pc_c/hata_c SHALL come from the FIFO head.
REQ-017 Issue: ena_c SHALL be 1 iff !rst_g && !dallan_g && (doluluk + ucus_r - cikis) < DERINLIK; on issue pc_r += 4 (mod 2^32, wrap from 32'hFFFF_FFFC to 0) and ucus_r <= 1, else ucus_r <= 0.
REQ-018 Capture: in a cycle with ucus_r == 1 and !dallan_g, buyruk_g SHALL be written to the FIFO tail tagged with the PC of the issuing cycle.
REQ-019 Simultaneous capture and pop SHALL be allowed; occupancy then SHALL be unchanged, and the FIFO SHALL never overflow or underflow.
REQ-020 Redirect: when dallan_g == 1, the FIFO SHALL be emptied, the in-flight response discarded, no issue made, and pc_r <= {dallan_adres_g[31:2], 2'b00}; a pop in that same cycle SHALL still complete.
REQ-021 Latency: an issue in cycle N SHALL yield gecerli_c == 1 for that word in cycle N+2; with hazir_g held at 1, throughput SHALL be one instruction per cycle.
REQ-022 Stall: with hazir_g == 0, the head beat and its outputs SHALL be held stable until popped.

Reset
REQ-023 On rst_g == 1: pc_r <= BASLANGIC_ADRES, ucus_r <= 0, FIFO emptied; gecerli_c, hata_c and ena_c SHALL be 0; buyruk_c/pc_c SHALL be 0.
REQ-024 The ROM's reset-loaded word SHALL be ignored; the first issue SHALL occur in the first cycle with rst_g == 0.
REQ-025 Reset asserted mid-operation SHALL discard the FIFO and in-flight data; reset SHALL have priority over dallan_g.

Configuration
REQ-026 Macro GETIR_ADRES_DENETIM_EN: when defined, a captured word whose PC word index (pc>>2) >= ROM_KELIME SHALL be replaced by 32'h0000_0013 (NOP) with hata = 1; when undefined, buyruk_g SHALL pass unmodified and hata_c SHALL be tied 0.

Verification
REQ-027 Reset release with hazir_g = 1 -> adres_c 0,4,8,... in cycles N,N+1,...; gecerli_c rises at N+2 with pc_c = 0 and buyruk_c = 32'h800000B7, then one beat per cycle.
REQ-028 hazir_g = 0 for 5 cycles after the first beat -> at most DERINLIK beats buffered, ena_c drops, pc_c stays 0; hazir_g = 1 -> beats 0,4,8 delivered in order, none lost or duplicated.
REQ-029 dallan_g pulse with target 32'h0000_004E while a fetch is in flight -> FIFO empty next cycle, next adres_c = 32'h0000_004C, next delivered pc_c = 32'h0000_004C.
REQ-030 dallan_g and a pop in the same cycle -> the popped beat is counted once; no stale beat appears afterward.
REQ-031 With GETIR_ADRES_DENETIM_EN defined, fetch from 32'h0000_00A4 (index 41) -> buyruk_c = 32'h0000_0013 and hata_c = 1; without the macro -> hata_c = 0.
REQ-032 rst_g asserted for one cycle while the FIFO is full -> gecerli_c = 0 in the next cycle, and the restart begins at BASLANGIC_ADRES.
